// File: rtl/sp_ram_fifo_ctrl.sv
// sp_ram_fifo_ctrl
//
// Turns a single-port RAM (one operation per cycle: RW_en=0 writes, RW_en=1
// reads with registered dout) into a 2**AW deep, DW wide FIFO. Both sides use
// valid/ready handshakes. The head word is held in a local output register.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   wr_valid      producer offers wr_data
//   wr_ready      write accepted this cycle when wr_valid && wr_ready
//   wr_data       write data
//   rd_valid      rd_data holds the FIFO head
//   rd_ready      consumer takes rd_data when rd_valid && rd_ready
//   rd_data       registered head data
//   level         words held: RAM entries + read in flight + output register
//   full          RAM holds 2**AW unread entries
//   empty         level == 0
//   ram_RW_en     RAM op select: 0 = write, 1 = read
//   ram_addr      RAM address
//   ram_din       RAM write data
//   ram_dout      RAM registered read data
module sp_ram_fifo_ctrl #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          ram_RW_en,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;     // unread entries still in RAM
  logic          rd_pend;   // read issued last edge, dout arrives now
  logic          rd_issue;
  logic          wr_accept;

  always_comb begin
    full = (count == DEPTH);
    // A read is issued only when the output register will be free by the
    // time dout arrives, and never back-to-back so the in-between cycle
    // is left for the write side.
    rd_issue  = !rst && (count != '0) && !rd_pend && (!rd_valid || rd_ready);
    wr_ready  = !rst && !full && !rd_issue;
    wr_accept = wr_valid && wr_ready;
    level     = count + {{AW{1'b0}}, rd_pend} + {{AW{1'b0}}, rd_valid};
    empty     = (level == '0);

    // Default is a harmless read at rd_ptr; RW_en drops only for an
    // accepted write, which already excludes a read issue.
    ram_RW_en = 1'b1;
    ram_addr  = rd_ptr;
    ram_din   = '0;
    if (wr_accept) begin
      ram_RW_en = 1'b0;
      ram_addr  = wr_ptr;
      ram_din   = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_pend  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end

      if (wr_accept) begin
        count <= count + CNT_ONE;
      end else if (rd_issue) begin
        count <= count - CNT_ONE;
      end

      rd_pend <= rd_issue;

      // A capture wins over a pop at the same edge.
      if (rd_pend) begin
        rd_data  <= ram_dout;
        rd_valid <= 1'b1;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Testbench for sp_ram_fifo_ctrl with a behavioural 16x8 single-port RAM and
// a queue-based FIFO reference model.
module tb_sp_ram_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          ram_RW_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sp_ram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .level(level), .full(full), .empty(empty),
    .ram_RW_en(ram_RW_en), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Single-port RAM: one operation per edge, registered read data.
  logic [DW-1:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    ram_dout = '0;
  end
  always @(posedge clk) begin
    if (!ram_RW_en) mem[ram_addr] <= ram_din;
    else            ram_dout      <= mem[ram_addr];
  end

  // Reference model: words accepted and not yet popped, in order, plus the
  // number of writes since reset (a write lands at that count modulo 16).
  logic [DW-1:0] q [$];
  int unsigned   wr_cnt = 0;

  always @(negedge clk) begin : scoreboard
    logic          wacc;
    logic [DW-1:0] exp_d;
    if (rst) begin
      total++;
      if (wr_ready !== 1'b0) $display("FAIL mon_rst_wr_ready: got %b expected 0", wr_ready);
      else passed++;
      total++;
      if (ram_RW_en !== 1'b1) $display("FAIL mon_rst_RW_en: got %b expected 1", ram_RW_en);
      else passed++;
      q.delete();
      wr_cnt = 0;
    end else begin
      total++;
      if (level !== 5'(q.size())) $display("FAIL mon_level: got %0d expected %0d", level, q.size());
      else passed++;
      total++;
      if (empty !== (q.size() == 0)) $display("FAIL mon_empty: got %b expected %b", empty, q.size() == 0);
      else passed++;
      if (q.size() == 17) begin
        total++;
        if (full !== 1'b1) $display("FAIL mon_full_set: got %b expected 1", full);
        else passed++;
      end
      if (q.size() < 16) begin
        total++;
        if (full !== 1'b0) $display("FAIL mon_full_clr: got %b expected 0", full);
        else passed++;
      end
      if (full === 1'b1) begin
        total++;
        if (wr_ready !== 1'b0) $display("FAIL mon_full_wr_ready: got %b expected 0", wr_ready);
        else passed++;
      end
      wacc = wr_valid && wr_ready;
      total++;
      if (ram_RW_en !== !wacc) $display("FAIL mon_RW_en: got %b expected %b", ram_RW_en, !wacc);
      else passed++;
      if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          $display("FAIL mon_pop_underflow: got pop of %0h expected no word", rd_data);
        end else begin
          exp_d = q.pop_front();
          if (rd_data !== exp_d) $display("FAIL mon_pop_data: got %0h expected %0h", rd_data, exp_d);
          else passed++;
        end
      end
      if (wacc) begin
        total++;
        if (ram_addr !== 4'(wr_cnt)) $display("FAIL mon_wr_addr: got %0d expected %0d", ram_addr, wr_cnt % 16);
        else passed++;
        total++;
        if (ram_din !== wr_data) $display("FAIL mon_wr_din: got %0h expected %0h", ram_din, wr_data);
        else passed++;
        q.push_back(wr_data);
        wr_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    bit ok;
    ok = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (wr_ready === 1'b1) ok = 1;
      tick();
    end
    wr_valid = 1'b0;
    total++;
    if (!ok) $display("FAIL push_timeout: got no wr_ready for %0h expected accept within 40 cycles", d);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b1; wr_data = 8'h5A; rd_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); else passed++;
      total++;
      if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); else passed++;
      total++;
      if (level !== 5'd0) $display("FAIL reset_level: got %0d expected 0", level); else passed++;
      total++;
      if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty); else passed++;
      total++;
      if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else passed++;
      total++;
      if (ram_RW_en !== 1'b1) $display("FAIL reset_RW_en: got %b expected 1", ram_RW_en); else passed++;
    end
    rst = 1'b0; wr_valid = 1'b0;
  endtask

  task automatic test_single_word();
    wr_valid = 1'b1; wr_data = 8'hA5; rd_ready = 1'b0;
    #1;
    total++;
    if (wr_ready !== 1'b1) $display("FAIL single_wr_ready: got %b expected 1", wr_ready); else passed++;
    total++;
    if (ram_RW_en !== 1'b0) $display("FAIL single_RW_en: got %b expected 0", ram_RW_en); else passed++;
    total++;
    if (ram_addr !== 4'd0) $display("FAIL single_addr: got %0d expected 0", ram_addr); else passed++;
    total++;
    if (ram_din !== 8'hA5) $display("FAIL single_din: got %0h expected a5", ram_din); else passed++;
    tick();  // accept edge
    wr_valid = 1'b0;
    #1;
    total++;
    if (ram_RW_en !== 1'b1) $display("FAIL single_issue_RW_en: got %b expected 1", ram_RW_en); else passed++;
    total++;
    if (rd_valid !== 1'b0) $display("FAIL single_early_valid1: got %b expected 0", rd_valid); else passed++;
    tick();  // issue edge
    total++;
    if (rd_valid !== 1'b0) $display("FAIL single_early_valid2: got %b expected 0", rd_valid); else passed++;
    total++;
    if (level !== 5'd1) $display("FAIL single_level_pend: got %0d expected 1", level); else passed++;
    tick();  // capture edge
    for (int c = 0; c < 4; c++) begin
      total++;
      if (rd_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", rd_valid); else passed++;
      total++;
      if (rd_data !== 8'hA5) $display("FAIL single_data: got %0h expected a5", rd_data); else passed++;
      total++;
      if (level !== 5'd1) $display("FAIL single_level: got %0d expected 1", level); else passed++;
      tick();
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    #1;
    total++;
    if (rd_valid !== 1'b0) $display("FAIL single_pop_valid: got %b expected 0", rd_valid); else passed++;
    total++;
    if (empty !== 1'b1) $display("FAIL single_pop_empty: got %b expected 1", empty); else passed++;
  endtask

  task automatic test_fill();
    rd_ready = 1'b0;
    for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
    #1;
    total++;
    if (full !== 1'b1) $display("FAIL fill_full: got %b expected 1", full); else passed++;
    total++;
    if (level !== 5'd17) $display("FAIL fill_level: got %0d expected 17", level); else passed++;
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h10) $display("FAIL fill_head: got %b/%0h expected 1/10", rd_valid, rd_data); else passed++;
    wr_valid = 1'b1; wr_data = 8'h99;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (wr_ready !== 1'b0) $display("FAIL fill_blocked_ready: got %b expected 0", wr_ready); else passed++;
      total++;
      if (ram_RW_en !== 1'b1) $display("FAIL fill_blocked_RW_en: got %b expected 1", ram_RW_en); else passed++;
      tick();
      total++;
      if (level !== 5'd17) $display("FAIL fill_blocked_level: got %0d expected 17", level); else passed++;
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_drain_wrap();
    int unsigned got;
    logic [DW-1:0] exp_d;
    got = 0;
    rd_ready = 1'b1;
    for (int c = 0; c < 100 && got < 17; c++) begin
      #1;
      if (rd_valid === 1'b1) begin
        exp_d = 8'(8'h10 + got);
        total++;
        if (rd_data !== exp_d) $display("FAIL drain_order: got %0h expected %0h", rd_data, exp_d); else passed++;
        got++;
      end
      tick();
    end
    total++;
    if (got != 17) $display("FAIL drain_count: got %0d expected 17", got); else passed++;
    tick(); tick();
    total++;
    if (empty !== 1'b1) $display("FAIL drain_empty: got %b expected 1", empty); else passed++;
    total++;
    if (level !== 5'd0) $display("FAIL drain_level: got %0d expected 0", level); else passed++;
    rd_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int unsigned sent, rcvd;
    logic prev_rw;
    sent = 0; rcvd = 0; prev_rw = 1'b1;
    rd_ready = 1'b1; wr_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      wr_data = 8'(8'h40 + sent);
      #1;
      if (rd_valid === 1'b1) begin
        total++;
        if (rd_data !== 8'(8'h40 + rcvd)) $display("FAIL stream_order: got %0h expected %0h", rd_data, 8'(8'h40 + rcvd)); else passed++;
        rcvd++;
      end
      total++;
      if (level > 5'd3) $display("FAIL stream_level: got %0d expected <= 3", level); else passed++;
      if (c >= 1) begin
        total++;
        if (ram_RW_en === prev_rw) $display("FAIL stream_alternate: got %b expected %b", ram_RW_en, !prev_rw); else passed++;
      end
      prev_rw = ram_RW_en;
      if (wr_ready === 1'b1) sent++;
      tick();
    end
    wr_valid = 1'b0;
    for (int c = 0; c < 20 && rcvd < sent; c++) begin
      #1;
      if (rd_valid === 1'b1) begin
        total++;
        if (rd_data !== 8'(8'h40 + rcvd)) $display("FAIL stream_tail: got %0h expected %0h", rd_data, 8'(8'h40 + rcvd)); else passed++;
        rcvd++;
      end
      tick();
    end
    total++;
    if (rcvd != sent || sent < 25) $display("FAIL stream_count: got %0d of %0d expected all of >= 25", rcvd, sent); else passed++;
    rd_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; tick(); rst = 1'b0;
    rd_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h50 + i));
    tick();
    rd_ready = 1'b1;  // pop the head, which also issues the next read
    tick();
    rd_ready = 1'b0;
    #1;
    total++;
    if (level !== 5'd5 || rd_valid !== 1'b0) $display("FAIL mid_setup: got level %0d valid %b expected 5/0", level, rd_valid); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (level !== 5'd0) $display("FAIL mid_level: got %0d expected 0", level); else passed++;
    total++;
    if (rd_valid !== 1'b0) $display("FAIL mid_valid: got %b expected 0", rd_valid); else passed++;
    tick();  // the stale read's dout must not be captured
    total++;
    if (rd_valid !== 1'b0) $display("FAIL mid_stale: got %b expected 0", rd_valid); else passed++;
    push(8'h3C);
    tick(); tick();
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h3C) $display("FAIL mid_readback: got %b/%0h expected 1/3c", rd_valid, rd_data); else passed++;
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 2500; c++) begin
      rst      = ($urandom_range(0, 499) == 0);
      wr_data  = 8'($urandom);
      if (((c / 250) % 2) == 0) begin
        wr_valid = ($urandom_range(0, 9) < 8);
        rd_ready = ($urandom_range(0, 9) < 2);
      end else begin
        wr_valid = ($urandom_range(0, 9) < 3);
        rd_ready = ($urandom_range(0, 9) < 8);
      end
      tick();
    end
    rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b1;
    for (int c = 0; c < 60; c++) tick();
    total++;
    if (empty !== 1'b1) $display("FAIL random_final_empty: got %b expected 1", empty); else passed++;
    rd_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    test_reset();
    test_single_word();
    test_fill();
    test_drain_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
